// File: rtl/register_file_param.sv
// Parametrised 2R/1W register file: clear walk after reset, per-entry valid bits.
// Optional same-cycle write-to-read bypass when REGFILE_BYPASS_EN is defined.
module register_file_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] rport1_addr,
  output logic [DATA_WIDTH-1:0] rport1_data,
  output logic                  rport1_valid,
  input  logic [ADDR_WIDTH-1:0] rport2_addr,
  output logic [DATA_WIDTH-1:0] rport2_data,
  output logic                  rport2_valid,
  input  logic                  wport_enable,
  input  logic [ADDR_WIDTH-1:0] wport_addr,
  input  logic [DATA_WIDTH-1:0] wport_data,
  output logic                  ready
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_idx_q, clr_idx_d;
  logic [DEPTH-1:0]        valid_q, valid_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  assign ready = (state_q == READY);

  // Single array write port shared by the clear walk and the writeback port.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    valid_d   = valid_q;
    mem_we    = 1'b0;
    mem_waddr = clr_idx_q;
    mem_wdata = '0;
    unique case (state_q)
      CLEAR: begin
        mem_we = 1'b1;
        if (clr_idx_q == LAST_IDX) begin
          state_d = READY;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
      READY: begin
        if (wport_enable) begin
          mem_we              = 1'b1;
          mem_waddr           = wport_addr;
          mem_wdata           = wport_data;
          valid_d[wport_addr] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      valid_q   <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      valid_q   <= valid_d;
    end
  end

  // The data array is deliberately left alone on the reset edge.
  always_ff @(posedge clk) begin
    if (reset_n && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    rport1_data  = '0;
    rport1_valid = 1'b0;
    if (ready) begin
      rport1_data  = mem_q[rport1_addr];
      rport1_valid = valid_q[rport1_addr];
`ifdef REGFILE_BYPASS_EN
      if (wport_enable && (rport1_addr == wport_addr)) begin
        rport1_data  = wport_data;
        rport1_valid = 1'b1;
      end
`endif
    end
  end

  always_comb begin
    rport2_data  = '0;
    rport2_valid = 1'b0;
    if (ready) begin
      rport2_data  = mem_q[rport2_addr];
      rport2_valid = valid_q[rport2_addr];
`ifdef REGFILE_BYPASS_EN
      if (wport_enable && (rport2_addr == wport_addr)) begin
        rport2_data  = wport_data;
        rport2_valid = 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_register_file_param.sv
// Directed bench for register_file_param: default 16x32 and a 8x16 instance.
// Bypass expectations follow REGFILE_BYPASS_EN.
module tb_register_file_param;

  logic        clk = 1'b0;
  logic        reset_n;

  logic [3:0]  r1a, r2a, wa;
  logic [31:0] r1d, r2d, wd;
  logic        r1v, r2v, we, rdy;

  logic [2:0]  s_r1a, s_r2a, s_wa;
  logic [15:0] s_r1d, s_r2d, s_wd;
  logic        s_r1v, s_r2v, s_we, s_rdy;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  register_file_param u_dut (
    .clk(clk), .reset_n(reset_n),
    .rport1_addr(r1a), .rport1_data(r1d), .rport1_valid(r1v),
    .rport2_addr(r2a), .rport2_data(r2d), .rport2_valid(r2v),
    .wport_enable(we), .wport_addr(wa), .wport_data(wd),
    .ready(rdy)
  );

  register_file_param #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) u_small (
    .clk(clk), .reset_n(reset_n),
    .rport1_addr(s_r1a), .rport1_data(s_r1d), .rport1_valid(s_r1v),
    .rport2_addr(s_r2a), .rport2_data(s_r2d), .rport2_valid(s_r2v),
    .wport_enable(s_we), .wport_addr(s_wa), .wport_data(s_wd),
    .ready(s_rdy)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  r1a;
    logic [3:0]  r2a;
    logic [31:0] e1;
    logic        ev1;
    logic [31:0] e2;
    logic        ev2;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{1'b1, 4'd0,  32'hF00AF00A, 4'd0,  4'd2,
                32'hF00AF00A, 1'b1, 32'h0, 1'b0};
    vecs[1] = '{1'b1, 4'd2,  32'hFFFFFFFF, 4'd0,  4'd2,
                32'hF00AF00A, 1'b1, 32'hFFFFFFFF, 1'b1};
    vecs[2] = '{1'b0, 4'd0,  32'h0,        4'd4,  4'd2,
                32'h0, 1'b0, 32'hFFFFFFFF, 1'b1};
    vecs[3] = '{1'b1, 4'd9,  32'h0000FFFF, 4'd9,  4'd9,
                32'h0000FFFF, 1'b1, 32'h0000FFFF, 1'b1};
    vecs[4] = '{1'b1, 4'd15, 32'h12345678, 4'd15, 4'd0,
                32'h12345678, 1'b1, 32'hF00AF00A, 1'b1};
    vecs[5] = '{1'b1, 4'd0,  32'h0,        4'd0,  4'd15,
                32'h0, 1'b1, 32'h12345678, 1'b1};

    reset_n = 1'b0;
    r1a = '0; r2a = '0; we = 1'b0; wa = '0; wd = '0;
    s_r1a = '0; s_r2a = '0; s_we = 1'b0; s_wa = '0; s_wd = '0;

    // Reset held for two edges
    repeat (2) @(posedge clk);
    #1;
    check("rst.ready", {31'b0, rdy}, 32'd0);
    check("rst.d1", r1d, 32'd0);
    check("rst.v1", {31'b0, r1v}, 32'd0);
    check("rst.d2", r2d, 32'd0);
    check("rst.v2", {31'b0, r2v}, 32'd0);
    check("rst.s_ready", {31'b0, s_rdy}, 32'd0);

    // Clear walk, with a dropped write to r3 on the 5th clear edge
    @(negedge clk);
    reset_n = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      if (e == 5) begin
        we = 1'b1; wa = 4'd3; wd = 32'h12345678;
      end
      @(posedge clk);
      #1;
      we = 1'b0;
      if (e < 16) check($sformatf("clr.ready%0d", e), {31'b0, rdy}, 32'd0);
      else        check("clr.ready16", {31'b0, rdy}, 32'd1);
      if (e == 3) begin
        check("clr.gate_d1", r1d, 32'd0);
        check("clr.gate_v1", {31'b0, r1v}, 32'd0);
      end
      if (e == 7) check("s_clr.ready7", {31'b0, s_rdy}, 32'd0);
      if (e == 8) check("s_clr.ready8", {31'b0, s_rdy}, 32'd1);
    end

    for (int i = 0; i < 16; i++) begin
      r1a = 4'(i);
      r2a = 4'(15 - i);
      #1;
      check($sformatf("clr.d1[%0d]", i), r1d, 32'd0);
      check($sformatf("clr.v1[%0d]", i), {31'b0, r1v}, 32'd0);
      check($sformatf("clr.d2[%0d]", 15 - i), r2d, 32'd0);
    end
    r1a = 4'd3;
    #1;
    check("wr_in_clear.d3", r1d, 32'd0);
    check("wr_in_clear.v3", {31'b0, r1v}, 32'd0);

    // Table-driven write/read vectors, checked after the write edge
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd;
      r1a = vecs[i].r1a; r2a = vecs[i].r2a;
      @(posedge clk);
      #1;
      we = 1'b0;
      #1;
      check($sformatf("vec%0d.d1", i), r1d, vecs[i].e1);
      check($sformatf("vec%0d.v1", i), {31'b0, r1v}, {31'b0, vecs[i].ev1});
      check($sformatf("vec%0d.d2", i), r2d, vecs[i].e2);
      check($sformatf("vec%0d.v2", i), {31'b0, r2v}, {31'b0, vecs[i].ev2});
    end

    // Bypass: r7 never written, read while writing
    @(negedge clk);
    r1a = 4'd7; r2a = 4'd9;
    we = 1'b1; wa = 4'd7; wd = 32'hDEADBEEF;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp.same_d1", r1d, 32'hDEADBEEF);
    check("byp.same_v1", {31'b0, r1v}, 32'd1);
`else
    check("byp.same_d1", r1d, 32'd0);
    check("byp.same_v1", {31'b0, r1v}, 32'd0);
`endif
    check("byp.other_d2", r2d, 32'h0000FFFF);
    @(posedge clk);
    #1;
    we = 1'b0;
    #1;
    check("byp.next_d1", r1d, 32'hDEADBEEF);
    check("byp.next_v1", {31'b0, r1v}, 32'd1);

    // Small instance: dual-port same address
    @(negedge clk);
    s_we = 1'b1; s_wa = 3'd5; s_wd = 16'h00FF;
    s_r1a = 3'd5; s_r2a = 3'd5;
    @(posedge clk);
    #1;
    s_we = 1'b0;
    #1;
    check("small.d1", {16'b0, s_r1d}, 32'h000000FF);
    check("small.d2", {16'b0, s_r2d}, 32'h000000FF);
    check("small.v1", {31'b0, s_r1v}, 32'd1);
    check("small.v2", {31'b0, s_r2v}, 32'd1);

    // Reset mid-operation
    @(negedge clk);
    we = 1'b1; wa = 4'd5; wd = 32'hA5A5A5A5;
    r1a = 4'd5; r2a = 4'd0;
    @(posedge clk);
    #1;
    we = 1'b0;
    #1;
    check("midrst.pre_d1", r1d, 32'hA5A5A5A5);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst.ready", {31'b0, rdy}, 32'd0);
    check("midrst.gate_d1", r1d, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      @(posedge clk);
      #1;
      if (e == 15) check("midrst.ready15", {31'b0, rdy}, 32'd0);
      if (e == 16) check("midrst.ready16", {31'b0, rdy}, 32'd1);
    end
    check("midrst.d5", r1d, 32'd0);
    check("midrst.v5", {31'b0, r1v}, 32'd0);
    check("midrst.d0", r2d, 32'd0);
    check("midrst.v0", {31'b0, r2v}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
